// File: rtl/glb_cmd_sequencer_pkg.sv
// Shared types for the global buffer command sequencer.
package glb_cmd_sequencer_pkg;

  localparam int unsigned GLB_DEPTH = 1024;
  localparam int unsigned GLB_CW    = $clog2(GLB_DEPTH) + 1;

  // Instruction encoding understood by the global buffer.
  typedef enum logic [2:0] {
    I_NOP           = 3'd0,
    LOAD_WEIGHT     = 3'd1,
    LOAD_ACTIVATION = 3'd2,
    LOAD_OUTPUT     = 3'd3,
    POINTER_RESET   = 3'd4,
    READ_ACTIVATION = 3'd5
  } global_buffer_instruction_t;

  typedef enum logic [3:0] {
    StIdle,
    StLdW,
    StLdA,
    StPrst1,
    StLdO,
    StPrst2,
    StRd,
    StRdWait,
    StDone
  } glb_seq_state_t;

  // One job descriptor: beat counts per phase.
  typedef struct packed {
    logic [GLB_CW-1:0] m;
    logic [GLB_CW-1:0] n;
    logic [GLB_CW-1:0] o;
    logic [GLB_CW-1:0] p;
  } glb_seq_job_t;

endpackage

// File: rtl/glb_rd_holding_reg.sv
// One-entry valid/ready holding register; refill may coincide with drain.
module glb_rd_holding_reg #(
  parameter int unsigned W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Load wins over drain so a same-cycle drain+refill leaves no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign free  = !valid_q || ready;

endmodule

// File: rtl/glb_cmd_sequencer.sv
// Issues the load/pointer-reset/read instruction stream for one job descriptor.
module glb_cmd_sequencer
  import glb_cmd_sequencer_pkg::*;
#(
  parameter int unsigned dataSize       = 8,
  parameter int unsigned interfaceDepth = 16,
  parameter int unsigned depth          = 1024,
  localparam int unsigned IW = interfaceDepth * dataSize,
  localparam int unsigned CW = $clog2(depth) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [CW-1:0]              n_weight_i,
  input  logic [CW-1:0]              n_act_i,
  input  logic [CW-1:0]              n_out_i,
  input  logic [CW-1:0]              n_read_i,
  output logic                       busy_o,
  output logic                       done_o,
  output global_buffer_instruction_t inst_o,
  input  logic                       glb_ready_i,
  input  logic                       ext_valid_i,
  output logic                       ext_ready_o,
  input  logic                       obuf_valid_i,
  output logic                       obuf_ready_o,
  input  logic [IW-1:0]              glb_rd_data_i,
  input  logic                       glb_rd_valid_i,
  output logic [IW-1:0]              rd_data_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i
);

  localparam logic [CW-1:0] One = CW'(1);

  glb_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_w_q, cnt_w_d, cnt_a_q, cnt_a_d;
  logic [CW-1:0]  cnt_o_q, cnt_o_d, cnt_p_q, cnt_p_d;
  logic           hold_load, hold_free;

  // State and phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_w_q <= '0;
      cnt_a_q <= '0;
      cnt_o_q <= '0;
      cnt_p_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_w_q <= cnt_w_d;
      cnt_a_q <= cnt_a_d;
      cnt_o_q <= cnt_o_d;
      cnt_p_q <= cnt_p_d;
    end
  end

  // Next state, counter updates and stream gating; zero-count phases are skipped.
  always_comb begin
    state_d      = state_q;
    cnt_w_d      = cnt_w_q;
    cnt_a_d      = cnt_a_q;
    cnt_o_d      = cnt_o_q;
    cnt_p_d      = cnt_p_q;
    inst_o       = I_NOP;
    ext_ready_o  = 1'b0;
    obuf_ready_o = 1'b0;
    done_o       = 1'b0;
    hold_load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_w_d = n_weight_i;
          cnt_a_d = n_act_i;
          cnt_o_d = n_out_i;
          cnt_p_d = n_read_i;
          if (n_weight_i != '0)   state_d = StLdW;
          else if (n_act_i != '0) state_d = StLdA;
          else                    state_d = StPrst1;
        end
      end
      StLdW: begin
        if (glb_ready_i && ext_valid_i) begin
          inst_o      = LOAD_WEIGHT;
          ext_ready_o = 1'b1;
          cnt_w_d     = cnt_w_q - One;
          if (cnt_w_q == One) state_d = (cnt_a_q != '0) ? StLdA : StPrst1;
        end
      end
      StLdA: begin
        if (glb_ready_i && ext_valid_i) begin
          inst_o      = LOAD_ACTIVATION;
          ext_ready_o = 1'b1;
          cnt_a_d     = cnt_a_q - One;
          if (cnt_a_q == One) state_d = StPrst1;
        end
      end
      StPrst1: begin
        inst_o  = POINTER_RESET;
        state_d = (cnt_o_q != '0) ? StLdO : StPrst2;
      end
      StLdO: begin
        if (glb_ready_i && obuf_valid_i) begin
          inst_o       = LOAD_OUTPUT;
          obuf_ready_o = 1'b1;
          cnt_o_d      = cnt_o_q - One;
          if (cnt_o_q == One) state_d = StPrst2;
        end
      end
      StPrst2: begin
        inst_o  = POINTER_RESET;
        state_d = (cnt_p_q != '0) ? StRd : StDone;
      end
      StRd: begin
        // Only request a beat when there is room to catch it.
        if (glb_ready_i && hold_free) begin
          inst_o  = READ_ACTIVATION;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        inst_o = READ_ACTIVATION;
        if (glb_rd_valid_i) begin
          hold_load = 1'b1;
          cnt_p_d   = cnt_p_q - One;
          state_d   = (cnt_p_q == One) ? StDone : StRd;
        end
      end
      StDone: begin
        if (!rd_valid_o) begin
          done_o  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle);

  glb_rd_holding_reg #(
    .W (IW)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .load_data (glb_rd_data_i),
    .ready     (rd_ready_i),
    .valid     (rd_valid_o),
    .data      (rd_data_o),
    .free      (hold_free)
  );

endmodule
